fft8_frame_ctrl: RTL and testbench
==================================

// Module: fft8_frame_ctrl
// PURPOSE
//  Frame sequencer for the 8-point FFT datapath.
//  - Accepts a valid/ready sample stream and drives the serial-to-parallel loader's enable and data, one sample per beat.
//  - Pads short frames with zeros on flush, then starts the FFT core.
//  - Waits for the core's done, then drains results through the parallel-to-serial unloader on a valid/ready stream.
//  - Sits between the system stream interfaces and the s2p / FFT core / p2s trio.
// PARAMETERS
//  N_PTS   8   points per frame; power of two >= 2
//  DATA_W  16  sample width, in and out
//  CNT_W   3   $clog2(N_PTS); sample/beat counter width
// PORTS
//  clk        in   1       clock, rising edge
//  reset_n    in   1       asynchronous, active-low reset; same net as s2p/p2s reset
//  in_valid   in   1       input sample valid
//  in_ready   out  1       input sample accepted when in_valid & in_ready
//  in_data    in   DATA_W  input sample
//  flush      in   1       single-cycle pulse: zero-pad and close the current partial frame
//  s2p_en     out  1       s2p load enable; s2p advances its index on every asserted cycle
//  s2p_din    out  DATA_W  s2p data: in_data, or 0 while padding
//  core_start out  1       one-cycle pulse; core captures the s2p outputs on this edge
//  core_done  in   1       one-cycle pulse from core: results valid
//  p2s_load   out  1       one-cycle pulse: p2s captures core results
//  p2s_shift  out  1       p2s advances one beat
//  out_valid  out  1       output beat valid
//  out_ready  in   1       downstream accepts beat
//  out_last   out  1       high on beat N_PTS-1 of a frame
//  out_padded out  1       current output frame contained zero padding
//  frame_cnt  out  16      completed output frames, wraps 0xFFFF->0
//  err        out  1       sticky: core_done received outside WAIT; cleared by reset only
// BEHAVIOUR
//  Reset values:
//  - in_ready=0, s2p_en=0, s2p_din=0, core_start=0, p2s_load=0, p2s_shift=0, out_valid=0, out_last=0, out_padded=0, frame_cnt=0, err=0.
//  - Both FSMs, icnt and ocnt return to their initial states.
//  Index alignment:
//  - The s2p index is not clearable, so icnt must mirror it exactly.
//  - Assert s2p_en only on accepted beats or pad cycles, never otherwise.
//  - Reset mid-frame realigns both only because they share reset_n; a partial frame is discarded.
//  Input FSM (FILL, PAD, HOLD):
//  - FILL: in_ready=1. On handshake: s2p_en=1, s2p_din=in_data (combinational), icnt++.
//    Handshake with icnt==N_PTS-1 -> HOLD, icnt=0.
//  - flush in FILL with icnt>0 -> PAD. With icnt==0, flush is ignored.
//  - flush plus handshake in the same cycle: the sample is accepted first.
//    If it was the last sample -> HOLD and flush is dropped; otherwise -> PAD.
//  - PAD: in_ready=0, s2p_en=1, s2p_din=0 every cycle, icnt++, pad_flag=1.
//    On wrap to 0 -> HOLD.
//  - HOLD: in_ready=0. core_start = (in_state==HOLD) && (out_state==IDLE).
//    On core_start: -> FILL; pad_flag is copied to out_padded, then cleared.
//  - Latency: last accepted sample at edge t -> core_start high in cycle t+1 if the output side is idle.
//    The first sample of the next frame is accepted in cycle t+2.
//  Output FSM (IDLE, WAIT, DRAIN):
//  - IDLE -> WAIT on core_start.
//  - WAIT -> DRAIN on core_done; p2s_load=1 that cycle (combinational); ocnt=0.
//  - DRAIN: out_valid=1, out_last=(ocnt==N_PTS-1).
//    On out_valid & out_ready: p2s_shift=1, ocnt++.
//    Last handshake -> IDLE, frame_cnt++.
//  - out_valid is never dropped without a handshake; a stall holds all outputs stable.
//  - Input fill overlaps WAIT/DRAIN freely. The next core_start waits for IDLE, at earliest the cycle after the last handshake.
//  - core_done in IDLE or DRAIN: ignored for sequencing, err<=1.
//  Arithmetic: icnt and ocnt are CNT_W wide and wrap naturally; frame_cnt is 16-bit and wraps.
// STRUCTURE
//  - Package fft8_pkg: N_PTS, DATA_W, CNT_W constants; in_state_t {FILL,PAD,HOLD}; out_state_t {IDLE,WAIT,DRAIN}.
//  - One natural sub-module, mod_n_counter (enable, wrap flag), used for both icnt and ocnt.
//  - Everything else stays flat in this module.
// TESTING
//  - Reset, then 8 back-to-back samples 1..8 -> s2p_en high exactly 8 cycles with s2p_din=1..8; core_start in cycle 9; in_ready low in cycle 9, high in cycle 10.
//  - 3 samples 0xA,0xB,0xC then flush -> 5 pad cycles with s2p_din=0, then core_start; after core_done, out_padded=1.
//  - core_done 4 cycles after core_start, out_ready always 1 -> p2s_load once, then 8 beats with out_last on beat 8 only; frame_cnt 0->1.
//  - out_ready toggling 1,0,0,1 during drain -> out_valid stays high, p2s_shift only on handshakes, exactly 8 shifts.
//  - Second frame fully loaded while first still draining -> core_start held off until the cycle after the first out_last handshake; no s2p_en in HOLD.
//  - Assert reset_n low after 5 samples, then send 8 fresh samples -> clean frame; spurious core_done while IDLE -> err=1, no p2s_load.

Source files
------------

// File: rtl/fft8_pkg.sv
// Shared constants and state encodings for the 8-point FFT frame sequencer.
package fft8_pkg;

  localparam int N_PTS  = 8;
  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(N_PTS);

  // Input side: collect samples, zero-pad a short frame, wait for the core.
  typedef enum logic [1:0] {
    FILL,
    PAD,
    HOLD
  } in_state_t;

  // Output side: wait for core results, then stream them out.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } out_state_t;

endpackage

// File: rtl/mod_n_counter.sv
// Free-running modulo-2^CNT_W counter with enable, synchronous clear and a
// wrap flag that is high in the cycle the counter rolls over to zero.
module mod_n_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i && !clr_i && (cnt_q == {CNT_W{1'b1}});

endmodule

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for the 8-point FFT: feeds the s2p loader from a sample
// stream (zero-padding short frames on flush), starts the core, and drains
// results through the p2s unloader onto an output stream.
module fft8_frame_ctrl
  import fft8_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              s2p_en,
  output logic [DATA_W-1:0] s2p_din,
  output logic              core_start,
  input  logic              core_done,
  output logic              p2s_load,
  output logic              p2s_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_padded,
  output logic [15:0]       frame_cnt,
  output logic              err
);

  in_state_t        in_state_q, in_state_d;
  out_state_t       out_state_q, out_state_d;
  logic             pad_flag_q, pad_flag_d;
  logic             out_padded_q, out_padded_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             err_q, err_d;

  logic             in_hs, out_hs;
  logic [CNT_W-1:0] icnt, ocnt;
  logic             icnt_wrap, ocnt_wrap;

  // Stream handshakes and datapath strobes. in_ready is gated by reset_n so
  // nothing is accepted while the s2p index is being held in reset.
  assign in_ready   = reset_n && (in_state_q == FILL);
  assign in_hs      = in_ready && in_valid;
  assign s2p_en     = in_hs || (in_state_q == PAD);
  assign s2p_din    = in_hs ? in_data : '0;
  assign core_start = (in_state_q == HOLD) && (out_state_q == IDLE);

  assign out_valid  = (out_state_q == DRAIN);
  assign out_hs     = out_valid && out_ready;
  assign p2s_shift  = out_hs;
  assign p2s_load   = (out_state_q == WAIT) && core_done;
  assign out_last   = out_valid && (ocnt == CNT_W'(N_PTS - 1));

  // icnt advances on exactly the cycles s2p does, so it mirrors the s2p index.
  mod_n_counter #(.CNT_W(CNT_W)) u_icnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (1'b0),
    .en_i    (s2p_en),
    .cnt_o   (icnt),
    .wrap_o  (icnt_wrap)
  );

  // ocnt counts output beats; realigned when the p2s captures a new frame.
  mod_n_counter #(.CNT_W(CNT_W)) u_ocnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (p2s_load),
    .en_i    (p2s_shift),
    .cnt_o   (ocnt),
    .wrap_o  (ocnt_wrap)
  );

  // Input FSM next state: fill, pad on flush, hold until the core is started.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    in_state_d   = in_state_q;
    pad_flag_d   = pad_flag_q;
    out_padded_d = out_padded_q;
    unique case (in_state_q)
      FILL: begin
        if (in_hs && icnt_wrap) begin
          in_state_d = HOLD;                 // last sample wins over flush
        end else if (flush && (in_hs || (icnt != '0))) begin
          in_state_d = PAD;
        end
      end
      PAD: begin
        pad_flag_d = 1'b1;
        if (icnt_wrap) begin
          in_state_d = HOLD;
        end
      end
      HOLD: begin
        if (core_start) begin
          in_state_d   = FILL;
          out_padded_d = pad_flag_q;
          pad_flag_d   = 1'b0;
        end
      end
      default: in_state_d = FILL;
    endcase
  end

  // Output FSM next state, frame counter and sticky protocol error.
  always_comb begin
    out_state_d = out_state_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    unique case (out_state_q)
      IDLE:    if (core_start) out_state_d = WAIT;
      WAIT:    if (core_done)  out_state_d = DRAIN;
      DRAIN: begin
        if (ocnt_wrap) begin
          out_state_d = IDLE;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: out_state_d = IDLE;
    endcase
    if (core_done && (out_state_q != WAIT)) begin
      err_d = 1'b1;
    end
  end

  // State and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_state_q   <= FILL;
      out_state_q  <= IDLE;
      pad_flag_q   <= 1'b0;
      out_padded_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      in_state_q   <= in_state_d;
      out_state_q  <= out_state_d;
      pad_flag_q   <= pad_flag_d;
      out_padded_q <= out_padded_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
    end
  end

  assign out_padded = out_padded_q;
  assign frame_cnt  = frame_cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Directed bench for fft8_frame_ctrl: inputs change 1 ns after the rising
// edge, outputs are checked 1 ns after that, well clear of the next edge.
module tb_fft8_frame_ctrl;
  import fft8_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush = 1'b0;
  logic              s2p_en;
  logic [DATA_W-1:0] s2p_din;
  logic              core_start;
  logic              core_done = 1'b0;
  logic              p2s_load;
  logic              p2s_shift;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              out_padded;
  logic [15:0]       frame_cnt;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;
  int shift_cnt = 0;
  int load_cnt  = 0;
  int s2p_cnt   = 0;

  always #5 clk = ~clk;

  fft8_frame_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .s2p_en     (s2p_en),
    .s2p_din    (s2p_din),
    .core_start (core_start),
    .core_done  (core_done),
    .p2s_load   (p2s_load),
    .p2s_shift  (p2s_shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_padded (out_padded),
    .frame_cnt  (frame_cnt),
    .err        (err)
  );

  // Pulse counters sampled on the active edge.
  always @(posedge clk) begin
    if (p2s_shift) shift_cnt <= shift_cnt + 1;
    if (p2s_load)  load_cnt  <= load_cnt + 1;
    if (s2p_en)    s2p_cnt   <= s2p_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drain one frame with out_ready held high from the current cycle.
  task automatic drain8(input string tag, input logic [15:0] fc_before);
    for (int b = 0; b < N_PTS; b++) begin
      out_ready = 1'b1;
      #1;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_shift"}, p2s_shift, 1);
      check({tag, "_last"}, out_last, (b == N_PTS - 1));
      check({tag, "_fc_pre"}, frame_cnt, fc_before);
      tick();
    end
    out_ready = 1'b0;
    #1;
    check({tag, "_valid_off"}, out_valid, 0);
    check({tag, "_fc_post"}, frame_cnt, fc_before + 16'd1);
  endtask

  int          sh0, ld0, s0, hs;
  logic [3:0]  pat;

  initial begin
    // ---------------- reset values ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_s2p_en", s2p_en, 0);
    check("rst_s2p_din", s2p_din, 0);
    check("rst_core_start", core_start, 0);
    check("rst_p2s_load", p2s_load, 0);
    check("rst_p2s_shift", p2s_shift, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_padded", out_padded, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err", err, 0);
    reset_n = 1'b1;

    // ---------------- full frame 1..8, no gaps ----------------
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(k);
      #1;
      check("t1_in_ready", in_ready, 1);
      check("t1_s2p_en", s2p_en, 1);
      check("t1_s2p_din", s2p_din, k);
      check("t1_no_start", core_start, 0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("t1_c9_in_ready", in_ready, 0);
    check("t1_c9_s2p_en", s2p_en, 0);
    check("t1_c9_core_start", core_start, 1);
    tick();
    flush = 1'b1;                         // flush with empty frame: ignored
    #1;
    check("t1_c10_in_ready", in_ready, 1);
    check("t1_c10_core_start", core_start, 0);
    check("t1_c10_s2p_en", s2p_en, 0);
    tick();
    flush = 1'b0;
    #1;
    check("t1_flush_ignored_rdy", in_ready, 1);
    check("t1_flush_ignored_en", s2p_en, 0);
    tick();
    tick();
    core_done = 1'b1;                     // 4 cycles after core_start
    #1;
    check("t1_p2s_load", p2s_load, 1);
    check("t1_wait_valid", out_valid, 0);
    tick();
    core_done = 1'b0;
    sh0 = shift_cnt;
    ld0 = load_cnt;
    drain8("t1_drain", 16'd0);
    check("t1_shifts", shift_cnt - sh0, 8);
    check("t1_loads_total", load_cnt, 1);
    check("t1_loads_after", load_cnt - ld0, 0);
    check("t1_err", err, 0);

    // ---------------- short frame + flush -> padding ----------------
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(16'hA + k);
      #1;
      check("t2_s2p_din", s2p_din, 16'hA + k);
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    #1;
    check("t2_flush_cyc_en", s2p_en, 0);
    tick();
    flush = 1'b0;
    for (int p = 0; p < 5; p++) begin
      #1;
      check("t2_pad_en", s2p_en, 1);
      check("t2_pad_din", s2p_din, 0);
      check("t2_pad_rdy", in_ready, 0);
      check("t2_pad_no_start", core_start, 0);
      tick();
    end
    #1;
    check("t2_core_start", core_start, 1);
    check("t2_hold_en", s2p_en, 0);
    tick();
    #1;
    check("t2_out_padded", out_padded, 1);
    tick();
    tick();
    core_done = 1'b1;
    #1;
    check("t2_p2s_load", p2s_load, 1);
    tick();
    core_done = 1'b0;
    sh0 = shift_cnt;
    pat = 4'b1001;                        // ready pattern 1,0,0,1
    hs  = 0;
    for (int j = 0; j < 40 && hs < 8; j++) begin
      out_ready = pat[j % 4];
      #1;
      check("t2_valid_held", out_valid, 1);
      check("t2_shift_on_hs", p2s_shift, out_ready);
      check("t2_last", out_last, (hs == 7));
      check("t2_padded_drain", out_padded, 1);
      if (out_ready) hs++;
      tick();
    end
    check("t2_handshakes", hs, 8);
    out_ready = 1'b0;
    #1;
    check("t2_valid_off", out_valid, 0);
    check("t2_shifts", shift_cnt - sh0, 8);
    check("t2_frame_cnt", frame_cnt, 2);

    // ---------------- second frame loaded during drain ----------------
    s0 = s2p_cnt;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(16'h20 + k);
      #1;
      check("t3a_rdy", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("t3a_core_start", core_start, 1);
    tick();
    core_done = 1'b1;
    #1;
    check("t3a_p2s_load", p2s_load, 1);
    check("t3a_out_padded", out_padded, 0);
    tick();
    core_done = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(16'h30 + k);
      flush    = (k == 7);                // flush with last sample: dropped
      #1;
      check("t3b_out_valid", out_valid, 1);
      check("t3b_rdy", in_ready, 1);
      check("t3b_s2p_din", s2p_din, 16'h30 + k);
      check("t3b_no_shift", p2s_shift, 0);
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (2) begin
      #1;
      check("t3_hold_s2p_en", s2p_en, 0);
      check("t3_hold_no_start", core_start, 0);
      check("t3_hold_rdy", in_ready, 0);
      check("t3_stall_valid", out_valid, 1);
      check("t3_stall_last", out_last, 0);
      tick();
    end
    for (int b = 0; b < 8; b++) begin
      out_ready = 1'b1;
      #1;
      check("t3_drain_no_start", core_start, 0);
      check("t3_drain_last", out_last, (b == 7));
      tick();
    end
    out_ready = 1'b0;
    #1;
    check("t3_core_start_after", core_start, 1);
    check("t3_out_valid_off", out_valid, 0);
    check("t3_frame_cnt", frame_cnt, 3);
    check("t3_s2p_count", s2p_cnt - s0, 16);
    tick();
    core_done = 1'b1;
    #1;
    check("t3b_p2s_load", p2s_load, 1);
    tick();
    core_done = 1'b0;
    drain8("t3b_drain", 16'd3);

    // ---------------- reset mid-frame, spurious core_done ----------------
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(16'h50 + k);
      tick();
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("t4_rst_rdy", in_ready, 0);
    check("t4_rst_fc", frame_cnt, 0);
    check("t4_rst_s2p_en", s2p_en, 0);
    tick();
    tick();
    reset_n   = 1'b1;
    core_done = 1'b1;                     // spurious while IDLE
    #1;
    check("t4_spurious_no_load", p2s_load, 0);
    tick();
    core_done = 1'b0;
    #1;
    check("t4_err", err, 1);
    check("t4_idle_valid", out_valid, 0);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(16'h40 + k);
      #1;
      check("t4_s2p_en", s2p_en, 1);
      check("t4_s2p_din", s2p_din, 16'h40 + k);
      check("t4_no_start", core_start, 0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("t4_core_start", core_start, 1);
    tick();
    core_done = 1'b1;
    #1;
    check("t4_p2s_load", p2s_load, 1);
    tick();
    core_done = 1'b0;
    drain8("t4_drain", 16'd0);
    check("t4_err_sticky", err, 1);
    check("t4_out_padded", out_padded, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
